// File: rtl/clk_fm_demod_sample_pwm.sv
// -----------------------------------------------------------------------------
// clk_fm_demod_sample_pwm
//
// Purpose:
//   Derives the audio-rate sampling strobe for the FM receiver by dividing the
//   ADC end-of-conversion pulse train (EOC) down to a PWM-shaped clock. While
//   enabled, the output has a period of DIVIDE EOC edges and is high for the
//   first HIGH_COUNT edges of each period. Disabling (or reset) parks the block
//   in an idle state from which the next enabled edge starts a fresh period
//   with the output high on that very edge.
//
// Parameters:
//   DIVIDE      EOC rising edges per output period (2..65535)
//   HIGH_COUNT  EOC edges per period with the output high (1..DIVIDE-1)
//
// Ports:
//   EOC                   in   sole clock, ADC end-of-conversion, rising edge
//   RSTn                  in   asynchronous active-low reset
//   FM_demod_en           in   demodulator enable, sampled on EOC rising edge
//   clk_fm_demo_sampling  out  divided PWM sampling clock, straight from a flop
// -----------------------------------------------------------------------------
module clk_fm_demod_sample_pwm #(
    parameter int DIVIDE     = 32,
    parameter int HIGH_COUNT = 16
) (
    input  logic EOC,
    input  logic RSTn,
    input  logic FM_demod_en,
    output logic clk_fm_demo_sampling
);

    localparam int             CW       = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DIVIDE - 1);
    localparam logic [CW-1:0]  HIGH_LIM = CW'(HIGH_COUNT);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    // Phase of the most recently processed EOC edge. The idle value is the
    // last phase, so the first enabled edge wraps to phase 0 and the output
    // goes high immediately, aligned to the enable.
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          out_reg;
    logic          out_next;

    always_comb begin
        cnt_next = CNT_LAST;
        out_next = 1'b0;
        if (FM_demod_en) begin
            cnt_next = (cnt_reg == CNT_LAST) ? '0 : (cnt_reg + CNT_ONE);
            // Output level follows the phase being entered on this edge.
            out_next = (cnt_next < HIGH_LIM);
        end
    end

    always_ff @(posedge EOC or negedge RSTn) begin
        if (!RSTn) begin
            cnt_reg <= CNT_LAST;
            out_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            out_reg <= out_next;
        end
    end

    assign clk_fm_demo_sampling = out_reg;

endmodule

// File: tb/tb_clk_fm_demod_sample_pwm.sv
// -----------------------------------------------------------------------------
// tb_clk_fm_demod_sample_pwm
//
// Exercises three instances sharing EOC/RSTn/FM_demod_en:
//   u_d32  DIVIDE=32, HIGH_COUNT=16 (defaults)
//   u_d5   DIVIDE=5,  HIGH_COUNT=2
//   u_d2   DIVIDE=2,  HIGH_COUNT=1
// Inputs are driven 1 time unit after each EOC rising edge and outputs are
// sampled at the same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_clk_fm_demod_sample_pwm;

    logic EOC;
    logic RSTn;
    logic FM_demod_en;
    logic out32;
    logic out5;
    logic out2;

    int n_tests;
    int n_fail;

    clk_fm_demod_sample_pwm u_d32 (
        .EOC                  (EOC),
        .RSTn                 (RSTn),
        .FM_demod_en          (FM_demod_en),
        .clk_fm_demo_sampling (out32)
    );

    clk_fm_demod_sample_pwm #(.DIVIDE(5), .HIGH_COUNT(2)) u_d5 (
        .EOC                  (EOC),
        .RSTn                 (RSTn),
        .FM_demod_en          (FM_demod_en),
        .clk_fm_demo_sampling (out5)
    );

    clk_fm_demod_sample_pwm #(.DIVIDE(2), .HIGH_COUNT(1)) u_d2 (
        .EOC                  (EOC),
        .RSTn                 (RSTn),
        .FM_demod_en          (FM_demod_en),
        .clk_fm_demo_sampling (out2)
    );

    initial EOC = 1'b0;
    always #5 EOC = ~EOC;

    typedef struct {
        logic en;
        logic e32;
        logic e5;
        logic e2;
    } vec_t;

    localparam int N_IDLE = 100;
    localparam int N_RUN  = 1000;
    localparam int N_VEC  = N_IDLE + N_RUN;

    vec_t vecs [N_VEC];

    task automatic chk(input string name, input int idx, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s idx=%0d got=%b expected=%b", name, idx, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int idx, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s idx=%0d got=%0d expected=%0d", name, idx, act, exp);
        end
    endtask

    // Advance one EOC rising edge and land 1 unit after it.
    task automatic step();
        @(posedge EOC);
        #1;
    endtask

    // Run n enabled edges from a fresh period: edge k (1-based) has phase k-1.
    task automatic run_enabled(input string tag, input int n);
        FM_demod_en = 1'b1;
        for (int k = 1; k <= n; k++) begin
            step();
            chk({tag, "_d32"}, k, out32, logic'(((k - 1) % 32) < 16));
            chk({tag, "_d5"},  k, out5,  logic'(((k - 1) % 5) < 2));
            chk({tag, "_d2"},  k, out2,  logic'(((k - 1) % 2) == 0));
            $display("[TB] %s edge=%0d out32=%b out5=%b out2=%b", tag, k, out32, out5, out2);
        end
    endtask

    initial begin
        int   rises;
        int   last_rise;
        int   high_cnt;
        logic prev32;

        n_tests = 0;
        n_fail  = 0;

        // Idle portion: enable low, everything parked at 0.
        for (int i = 0; i < N_IDLE; i++) begin
            vecs[i].en  = 1'b0;
            vecs[i].e32 = 1'b0;
            vecs[i].e5  = 1'b0;
            vecs[i].e2  = 1'b0;
        end
        // Enabled portion from a fresh start: 32-edge period with 16 high,
        // 5-edge period with 2 high, and a toggle for DIVIDE=2.
        for (int i = 0; i < N_RUN; i++) begin
            vecs[N_IDLE + i].en  = 1'b1;
            vecs[N_IDLE + i].e32 = logic'((i % 32) < 16);
            vecs[N_IDLE + i].e5  = logic'((i % 5) < 2);
            vecs[N_IDLE + i].e2  = logic'((i % 2) == 0);
        end

        // ---------------- Reset held with EOC running (enable high too) ----
        RSTn        = 1'b0;
        FM_demod_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rst_d32", i, out32, 1'b0);
            chk("rst_d5",  i, out5,  1'b0);
            chk("rst_d2",  i, out2,  1'b0);
            $display("[TB] reset edge=%0d out32=%b out5=%b out2=%b", i, out32, out5, out2);
        end
        FM_demod_en = 1'b0;
        RSTn        = 1'b1;   // released 1 unit after an edge, far from the next

        // ---------------- Table: 100 idle edges, then 1000 enabled edges ----
        rises     = 0;
        last_rise = 0;
        high_cnt  = 0;
        prev32    = 1'b0;
        for (int i = 0; i < N_VEC; i++) begin
            FM_demod_en = vecs[i].en;
            step();
            chk("tbl_d32", i, out32, vecs[i].e32);
            chk("tbl_d5",  i, out5,  vecs[i].e5);
            chk("tbl_d2",  i, out2,  vecs[i].e2);
            $display("[TB] vec=%0d en=%b out32=%b out5=%b out2=%b", i, vecs[i].en, out32, out5, out2);

            if (i >= N_IDLE) begin
                if (out32 && !prev32) begin
                    if (i < N_IDLE + 320) rises++;
                    if (last_rise != 0) begin
                        chk_int("period_len", i, i - last_rise, 32);
                        chk_int("period_high", i, high_cnt, 16);
                    end
                    last_rise = i;
                    high_cnt  = 0;
                end
                if (out32) high_cnt++;
            end
            prev32 = out32;
            if (i == N_IDLE + 319) chk_int("rises_in_320", i, rises, 10);
        end

        // ---------------- Disable mid-period -------------------------------
        // Last table edge sits at phase 7 of the 32 period (output high).
        FM_demod_en = 1'b0;
        step();
        chk("dis_d32", 0, out32, 1'b0);
        chk("dis_d5",  0, out5,  1'b0);
        chk("dis_d2",  0, out2,  1'b0);
        $display("[TB] disable edge out32=%b out5=%b out2=%b", out32, out5, out2);
        run_enabled("reen", 40);

        // Short enable, then drop enable after 5 edges while output is high.
        FM_demod_en = 1'b0;
        step();
        run_enabled("en5", 5);
        FM_demod_en = 1'b0;
        step();
        chk("dis5_d32", 0, out32, 1'b0);
        chk("dis5_d5",  0, out5,  1'b0);
        $display("[TB] disable-after-5 out32=%b out5=%b out2=%b", out32, out5, out2);
        run_enabled("reen5", 64);

        // ---------------- Async reset mid-high -----------------------------
        FM_demod_en = 1'b0;
        step();
        run_enabled("pre_rst", 8);
        chk("pre_rst_high", 0, out32, 1'b1);
        #1;
        RSTn = 1'b0;          // between EOC edges
        #1;
        chk("async_d32", 0, out32, 1'b0);
        chk("async_d5",  0, out5,  1'b0);
        chk("async_d2",  0, out2,  1'b0);
        $display("[TB] async reset out32=%b out5=%b out2=%b", out32, out5, out2);
        #1;
        RSTn = 1'b1;          // released well before the next rising edge
        run_enabled("post_rst", 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_fm_demod_sample_pwm.md
# clk_fm_demod_sample_pwm

Generates the audio-rate sampling strobe for the FM receiver by dividing the ADC end-of-conversion pulse train (EOC) down to a PWM-shaped clock. It sits inside the FM demodulation path. Its output clocks the downsampling register that captures the filtered demodulator result. The block runs entirely in the EOC domain and is gated by the demodulator enable.

## Interface
Parameters:
- DIVIDE, 32: number of EOC rising edges per output period; legal range 2..65535.
- HIGH_COUNT, 16: number of EOC edges per period during which the output is high; legal range 1..DIVIDE-1.

Ports:
- EOC  input  1  sole clock; ADC end-of-conversion pulse, rising-edge active.
- RSTn  input  1  asynchronous, active-low reset.
- FM_demod_en  input  1  enable; sampled on EOC rising edge.
- clk_fm_demo_sampling  output  1  divided PWM sampling clock, registered.

One clock (EOC); reset RSTn is asynchronous and active-low.

## Operation
- Internal counter `cnt`, width ceil(log2(DIVIDE)) bits. It holds the phase of the most recently processed EOC edge.
- Reset (RSTn=0, asynchronous, immediate):
  - `cnt` = DIVIDE-1.
  - clk_fm_demo_sampling = 0.
- Each EOC rising edge with RSTn=1 and FM_demod_en=0 (disabled):
  - `cnt` <= DIVIDE-1.
  - Output <= 0.
  - This is the same idle state as reset.
- Each EOC rising edge with FM_demod_en=1 (enabled):
  - cnt_next = 0 if `cnt` == DIVIDE-1, else `cnt`+1.
  - `cnt` <= cnt_next.
  - Output <= 1 if cnt_next < HIGH_COUNT, else 0.
- Resulting output waveform while enabled:
  - Period is exactly DIVIDE EOC edges.
  - High for HIGH_COUNT edges, then low for DIVIDE-HIGH_COUNT edges.
  - The output rises on edges where cnt_next = 0.
- The counter wraps from DIVIDE-1 to 0 with no skipped or duplicated phase.
- The output is driven directly from a flop; no combinational path from any input to the output.
- No other state. Parameter values outside the legal range are unsupported; the implementation may flag them with an elaboration-time check.

## Timing
- Latency: the output changes only on an EOC rising edge (or immediately on reset assertion), with one edge of register delay from the enable sample.
- Enable rise: the first enabled EOC edge yields cnt_next=0 and drives the output high on that edge. The output is therefore phase-aligned to the enable with zero extra edges.
- Enable fall mid-period:
  - The next EOC edge forces the output to 0 and restarts the phase.
  - No partial period is completed.
  - Re-enable starts a fresh period as above.
- Reset asserted mid-period: the output drops to 0 asynchronously and `cnt` is set to DIVIDE-1. After release, behaviour is identical to power-up.
- Reset release coincident with an EOC edge: that edge may be either honored or ignored. The bench must not depend on it.
- FM_demod_en must be stable around the EOC rising edge; it is not synchronized internally.

## Test plan
- Reset: assert RSTn=0 with EOC toggling -> output 0 continuously; after release with en=0, output stays 0 for 100 EOC edges.
- Default params, en=1 from reset release:
  - Output high on edges 1..16 and low on edges 17..32.
  - Output rises again on edge 33.
  - Exactly 10 rising edges of the output in 320 EOC edges.
- Disable mid-period: enable, run 5 edges (output high), drop en -> output 0 on the next EOC edge. Re-enable -> output high on the first enabled edge, then 16 high / 16 low.
- Async reset mid-high: after 8 enabled edges, pulse RSTn low between EOC edges -> output falls immediately with no EOC edge. After release, the sequence restarts at cnt_next=0.
- DIVIDE=5, HIGH_COUNT=2, en=1 -> output pattern repeats 1,1,0,0,0 per edge; DIVIDE=2, HIGH_COUNT=1 -> output toggles every edge.
- Wrap check: with DIVIDE=32, run 1000 enabled edges -> every output period measures exactly 32 edges with exactly 16 high.
